// File: rtl/frame_scheduler.sv
// Per-frame sequencer: runs the player updater, commits its pose, then runs the renderer.
// It owns the authoritative player pose and the shared grid-map read address.
module frame_scheduler #(
    parameter logic [13:0] START_X     = 14'd512,
    parameter logic [12:0] START_Y     = 13'd512,
    parameter logic [7:0]  START_ANGLE = 8'd0,
    parameter logic [23:0] TIMEOUT     = 24'd2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync,
    output logic        pu_start,
    input  logic        pu_done,
    input  logic [13:0] pu_next_pos_x,
    input  logic [12:0] pu_next_pos_y,
    input  logic [7:0]  pu_next_angle,
    output logic [13:0] cur_pos_x,
    output logic [12:0] cur_pos_y,
    output logic [7:0]  cur_angle,
    output logic        render_start,
    input  logic        render_done,
    input  logic [5:0]  pu_grid_x,
    input  logic [4:0]  pu_grid_y,
    input  logic [5:0]  rc_grid_x,
    input  logic [4:0]  rc_grid_y,
    output logic [5:0]  grid_x,
    output logic [4:0]  grid_y,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        overrun,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PU_START = 3'd1,
        S_PU_WAIT  = 3'd2,
        S_COMMIT   = 3'd3,
        S_R_START  = 3'd4,
        S_R_WAIT   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        overrun_q, overrun_d;
    logic        timeout_err_q, timeout_err_d;
    logic        pu_start_q, pu_start_d;
    logic        render_start_q, render_start_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [23:0] wait_cnt_q, wait_cnt_d;
    logic [13:0] cur_pos_x_q, cur_pos_x_d;
    logic [12:0] cur_pos_y_q, cur_pos_y_d;
    logic [7:0]  cur_angle_q, cur_angle_d;
    logic        wait_expired;
    logic        in_wait;

    assign wait_expired = (wait_cnt_q == TIMEOUT - 24'd1);
    assign in_wait      = (state_q == S_PU_WAIT) || (state_q == S_R_WAIT);

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        overrun_d      = overrun_q;
        timeout_err_d  = timeout_err_q;
        frame_count_d  = frame_count_q;
        cur_pos_x_d    = cur_pos_x_q;
        cur_pos_y_d    = cur_pos_y_q;
        cur_angle_d    = cur_angle_q;

        case (state_q)
            S_IDLE: begin
                if (vsync || pending_q) state_d = S_PU_START;
            end
            S_PU_START: state_d = S_PU_WAIT;
            S_PU_WAIT: begin
                if (pu_done) begin
                    state_d = S_COMMIT;
                end else if (wait_expired) begin
                    state_d       = S_R_START;
                    timeout_err_d = 1'b1;
                end
            end
            S_COMMIT: begin
                cur_pos_x_d = pu_next_pos_x;
                cur_pos_y_d = pu_next_pos_y;
                cur_angle_d = pu_next_angle;
                state_d     = S_R_START;
            end
            S_R_START: state_d = S_R_WAIT;
            S_R_WAIT: begin
                if (render_done) begin
                    state_d       = S_IDLE;
                    frame_count_d = frame_count_q + 16'd1;
                end else if (wait_expired) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A tick arriving in PU_START is a fresh one, so it re-arms the slot being consumed.
        if (state_q == S_PU_START) pending_d = 1'b0;
        if (vsync && (state_q != S_IDLE)) begin
            if (pending_q && (state_q != S_PU_START)) overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        wait_cnt_d     = (in_wait && (state_d == state_q)) ? wait_cnt_q + 24'd1 : 24'd0;
        pu_start_d     = (state_d == S_PU_START);
        render_start_d = (state_d == S_R_START);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            pu_start_q     <= 1'b0;
            render_start_q <= 1'b0;
            frame_count_q  <= 16'd0;
            wait_cnt_q     <= 24'd0;
            cur_pos_x_q    <= START_X;
            cur_pos_y_q    <= START_Y;
            cur_angle_q    <= START_ANGLE;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
            pu_start_q     <= pu_start_d;
            render_start_q <= render_start_d;
            frame_count_q  <= frame_count_d;
            wait_cnt_q     <= wait_cnt_d;
            cur_pos_x_q    <= cur_pos_x_d;
            cur_pos_y_q    <= cur_pos_y_d;
            cur_angle_q    <= cur_angle_d;
        end
    end

    assign pu_start     = pu_start_q;
    assign render_start = render_start_q;
    assign cur_pos_x    = cur_pos_x_q;
    assign cur_pos_y    = cur_pos_y_q;
    assign cur_angle    = cur_angle_q;
    assign frame_count  = frame_count_q;
    assign overrun      = overrun_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state    = state_q;

    always_comb begin
        grid_x = rc_grid_x;
        grid_y = rc_grid_y;
        if ((state_q == S_PU_START) || (state_q == S_PU_WAIT)) begin
            grid_x = pu_grid_x;
            grid_y = pu_grid_y;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a frame-level reference model checked every cycle,
// plus hand-computed checkpoints on the scenarios of interest.
module tb_frame_scheduler;

  localparam int TMO = 16;
  localparam int PH_IDLE = 0, PH_PU_GO = 1, PH_PU_RUN = 2, PH_SAVE = 3, PH_R_GO = 4, PH_R_RUN = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        vsync = 1'b0, pu_done = 1'b0, render_done = 1'b0;
  logic [13:0] pu_next_pos_x = 14'd0;
  logic [12:0] pu_next_pos_y = 13'd0;
  logic [7:0]  pu_next_angle = 8'd0;
  logic [5:0]  pu_grid_x = 6'd3, rc_grid_x = 6'd7;
  logic [4:0]  pu_grid_y = 5'd4, rc_grid_y = 5'd9;
  logic        pu_start, render_start, busy, overrun, timeout_err;
  logic [13:0] cur_pos_x;
  logic [12:0] cur_pos_y;
  logic [7:0]  cur_angle;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic [15:0] frame_count;
  logic [2:0]  dbg_state;

  frame_scheduler #(
    .START_X(14'd512), .START_Y(13'd512), .START_ANGLE(8'd0), .TIMEOUT(24'd16)
  ) dut (
    .clock(clock), .reset(reset), .vsync(vsync),
    .pu_start(pu_start), .pu_done(pu_done),
    .pu_next_pos_x(pu_next_pos_x), .pu_next_pos_y(pu_next_pos_y), .pu_next_angle(pu_next_angle),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .render_start(render_start), .render_done(render_done),
    .pu_grid_x(pu_grid_x), .pu_grid_y(pu_grid_y), .rc_grid_x(rc_grid_x), .rc_grid_y(rc_grid_y),
    .grid_x(grid_x), .grid_y(grid_y), .busy(busy), .frame_count(frame_count),
    .overrun(overrun), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic cmp_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: where the frame is, how long it has waited, and what it has committed.
  int          m_phase = PH_IDLE;
  int          m_waited = 0;
  logic        m_tick_queued = 1'b0;
  logic        m_ovr = 1'b0, m_terr = 1'b0;
  logic [15:0] m_fc = 16'd0;
  logic [13:0] m_x = 14'd512;
  logic [12:0] m_y = 13'd512;
  logic [7:0]  m_a = 8'd0;

  always @(posedge clock) begin
    int   nxt;
    logic queued;
    if (reset) begin
      m_phase = PH_IDLE; m_waited = 0; m_tick_queued = 1'b0;
      m_ovr = 1'b0; m_terr = 1'b0; m_fc = 16'd0;
      m_x = 14'd512; m_y = 13'd512; m_a = 8'd0;
    end else begin
      nxt    = m_phase;
      queued = (m_phase == PH_PU_GO) ? 1'b0 : m_tick_queued;
      if (vsync && m_phase != PH_IDLE) begin
        if (queued) m_ovr = 1'b1;
        queued = 1'b1;
      end
      if (m_phase == PH_IDLE && (vsync || m_tick_queued)) nxt = PH_PU_GO;
      else if (m_phase == PH_PU_GO) nxt = PH_PU_RUN;
      else if (m_phase == PH_PU_RUN) begin
        if (pu_done) nxt = PH_SAVE;
        else if (m_waited + 1 >= TMO) begin nxt = PH_R_GO; m_terr = 1'b1; end
      end else if (m_phase == PH_SAVE) begin
        m_x = pu_next_pos_x; m_y = pu_next_pos_y; m_a = pu_next_angle;
        nxt = PH_R_GO;
      end else if (m_phase == PH_R_GO) nxt = PH_R_RUN;
      else if (m_phase == PH_R_RUN) begin
        if (render_done) begin nxt = PH_IDLE; m_fc = m_fc + 16'd1; end
        else if (m_waited + 1 >= TMO) begin nxt = PH_IDLE; m_terr = 1'b1; end
      end
      m_waited      = (nxt == m_phase) ? m_waited + 1 : 0;
      m_phase       = nxt;
      m_tick_queued = queued;
    end
  end

  // Compare process
  always @(negedge clock) begin
    if (cmp_en) begin
      check("busy", busy, m_phase != PH_IDLE);
      check("pu_start", pu_start, m_phase == PH_PU_GO);
      check("render_start", render_start, m_phase == PH_R_GO);
      check("grid", {grid_x, grid_y},
            (m_phase == PH_PU_GO || m_phase == PH_PU_RUN) ? {pu_grid_x, pu_grid_y} : {rc_grid_x, rc_grid_y});
      check("pose", {cur_pos_x, cur_pos_y, cur_angle}, {m_x, m_y, m_a});
      check("frame_count", frame_count, m_fc);
      check("overrun", overrun, m_ovr);
      check("timeout_err", timeout_err, m_terr);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pu_start(input string name);
    int n = 0;
    @(negedge clock);
    while (!pu_start && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, pu_start, 1'b1);
    step();
  endtask

  task automatic wait_render_start(input string name);
    int n = 0;
    @(negedge clock);
    while (!render_start && n < 40) begin
      @(negedge clock);
      n++;
    end
    check(name, render_start, 1'b1);
    step();
  endtask

  // Called in the cycle after pu_start; pd/rd count cycles after each start pulse.
  task automatic finish_frame(input int pd, input int rd,
                              input logic [13:0] nx, input logic [12:0] ny, input logic [7:0] na);
    pu_next_pos_x = nx; pu_next_pos_y = ny; pu_next_angle = na;
    repeat (pd - 1) step();
    pu_done = 1'b1; step(); pu_done = 1'b0;
    wait_render_start("render_start_wait");
    repeat (rd - 1) step();
    render_done = 1'b1; step(); render_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    // Reset and idle
    step();
    cmp_en = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_pose", {cur_pos_x, cur_pos_y, cur_angle}, {14'd512, 13'd512, 8'd0});
    check("rst_grid", {grid_x, grid_y}, {6'd7, 5'd9});
    check("rst_fc", frame_count, 16'd0);

    // Basic frame: vsync, done 5 after pu_start, render_done 3 after render_start
    repeat (7) step();
    vsync = 1'b1; step(); vsync = 1'b0;
    @(negedge clock);
    check("t1_pu_start", pu_start, 1'b1);
    check("t1_grid_pu", {grid_x, grid_y}, {6'd3, 5'd4});
    step();
    pu_next_pos_x = 14'd600; pu_next_pos_y = 13'd520; pu_next_angle = 8'd8;
    repeat (4) step();
    pu_done = 1'b1; step(); pu_done = 1'b0;
    @(negedge clock);
    check("t1_commit_grid", {grid_x, grid_y}, {6'd7, 5'd9});
    check("t1_pose_not_yet", {cur_pos_x, cur_pos_y, cur_angle}, {14'd512, 13'd512, 8'd0});
    step();
    @(negedge clock);
    check("t1_pose", {cur_pos_x, cur_pos_y, cur_angle}, {14'd600, 13'd520, 8'd8});
    check("t1_render_start", render_start, 1'b1);
    step(); step(); step();
    render_done = 1'b1; step(); render_done = 1'b0;
    @(negedge clock);
    check("t1_busy_after", busy, 1'b0);
    check("t1_fc", frame_count, 16'd1);

    // One tick during R_WAIT: one idle cycle, then pu_start, no overrun
    step();
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_pu_start("t3a_pu_start");
    pu_done = 1'b1; step(); pu_done = 1'b0;
    wait_render_start("t3a_render_start");
    vsync = 1'b1; step(); vsync = 1'b0;
    step();
    render_done = 1'b1; step(); render_done = 1'b0;
    @(negedge clock);
    check("t3a_idle_gap", busy, 1'b0);
    check("t3a_overrun", overrun, 1'b0);
    step();
    @(negedge clock);
    check("t3a_pending_start", pu_start, 1'b1);
    step();
    finish_frame(2, 2, 14'd50, 13'd60, 8'd70);
    @(negedge clock);
    check("t3a_fc", frame_count, 16'd3);

    // Three ticks during one frame: overrun, exactly one extra frame
    step();
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_pu_start("t3b_pu_start");
    repeat (3) begin
      vsync = 1'b1; step(); vsync = 1'b0; step();
    end
    finish_frame(1, 2, 14'd100, 13'd200, 8'd30);
    @(negedge clock);
    check("t3b_overrun", overrun, 1'b1);
    wait_pu_start("t3b_extra_frame");
    finish_frame(2, 1, 14'd100, 13'd200, 8'd30);
    repeat (10) step();
    @(negedge clock);
    check("t3b_settled", busy, 1'b0);
    check("t3b_fc", frame_count, 16'd5);

    // Player updater never answers: timeout after 16 wait cycles, no commit
    step();
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_pu_start("t4_pu_start");
    pu_next_pos_x = 14'd1; pu_next_pos_y = 13'd2; pu_next_angle = 8'd3;
    repeat (15) step();
    @(negedge clock);
    check("t4_still_waiting", render_start, 1'b0);
    check("t4_no_err_yet", timeout_err, 1'b0);
    step();
    @(negedge clock);
    check("t4_render_start", render_start, 1'b1);
    check("t4_pose_kept", {cur_pos_x, cur_pos_y, cur_angle}, {14'd100, 13'd200, 8'd30});
    check("t4_timeout_err", timeout_err, 1'b1);
    step();
    render_done = 1'b1; step(); render_done = 1'b0;
    @(negedge clock);
    check("t4_fc", frame_count, 16'd6);

    // Reset during R_WAIT, then stray done pulses
    step();
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_pu_start("t5_pu_start");
    pu_done = 1'b1; step(); pu_done = 1'b0;
    wait_render_start("t5_render_start");
    reset = 1'b1; step(); reset = 1'b0;
    @(negedge clock);
    check("t5_busy", busy, 1'b0);
    check("t5_pose", {cur_pos_x, cur_pos_y, cur_angle}, {14'd512, 13'd512, 8'd0});
    check("t5_fc", frame_count, 16'd0);
    check("t5_flags", {overrun, timeout_err}, 2'b00);
    step();
    render_done = 1'b1; step(); render_done = 1'b0;
    pu_done = 1'b1; step(); pu_done = 1'b0;
    @(negedge clock);
    check("t5_stray_fc", frame_count, 16'd0);
    check("t5_stray_busy", busy, 1'b0);

    // Frame counter wrap from 16'hFFFF, also timing a minimum-length frame
    step();
    force dut.frame_count_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    step();
    release dut.frame_count_q;
    @(negedge clock);
    check("t6_preload", frame_count, 16'hFFFF);
    step();
    c0 = cyc;
    vsync = 1'b1; step(); vsync = 1'b0;
    wait_pu_start("t6_pu_start");
    finish_frame(1, 1, 14'd9, 13'd9, 8'd9);
    check("t6_min_frame_len", cyc - c0, 6);
    @(negedge clock);
    check("t6_wrap", frame_count, 16'd0);
    check("t6_idle", busy, 1'b0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Top-level frame sequencer for the game loop. Once per frame tick it runs two phases: it starts the player updater and waits for it, commits the new pose, then starts the renderer and waits for it. It owns the authoritative player pose registers (`cur_pos_x`, `cur_pos_y`, `cur_angle`) that feed both engines. It also arbitrates the single grid-map read port between the player updater and the renderer.

## Interface
Parameters:
- `START_X`, default 14'd512: `cur_pos_x` value after reset.
- `START_Y`, default 13'd512: `cur_pos_y` value after reset.
- `START_ANGLE`, default 8'd0: `cur_angle` value after reset.
- `TIMEOUT`, default 24'd2000000: maximum cycles spent in either wait state.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: frame tick, 1-cycle pulse.
- `pu_start` out 1: 1-cycle start pulse to the player updater.
- `pu_done` in 1: 1-cycle done pulse from the player updater.
- `pu_next_pos_x` in 14, `pu_next_pos_y` in 13, `pu_next_angle` in 8: pose proposed by the player updater.
- `cur_pos_x` out 14, `cur_pos_y` out 13, `cur_angle` out 8: registered authoritative pose.
- `render_start` out 1: 1-cycle start pulse to the renderer.
- `render_done` in 1: 1-cycle done pulse from the renderer.
- `pu_grid_x` in 6, `pu_grid_y` in 5: grid address from the player updater.
- `rc_grid_x` in 6, `rc_grid_y` in 5: grid address from the renderer.
- `grid_x` out 6, `grid_y` out 5: muxed address to the grid map.
- `busy` out 1: high in every state except IDLE.
- `frame_count` out 16: completed frames; wraps 16'hFFFF -> 0.
- `overrun` out 1: sticky; set when a frame tick is lost.
- `timeout_err` out 1: sticky; set when a wait state times out.

## Operation
- States: IDLE, PU_START, PU_WAIT, COMMIT, R_START, R_WAIT.
- IDLE -> PU_START when `vsync` or `pending` is high; otherwise stay in IDLE.
- PU_START: `pu_start`=1 for this cycle only; clear `pending`. Next state is always PU_WAIT.
- PU_WAIT:
  - `pu_done` -> COMMIT.
  - Wait counter reaches TIMEOUT-1 without `pu_done` -> R_START; no commit; set `timeout_err`.
- COMMIT: load `cur_*` <= `pu_next_*`. Next state is always R_START.
- R_START: `render_start`=1 for this cycle only. Next state is always R_WAIT.
- R_WAIT:
  - `render_done` -> IDLE; `frame_count` increments.
  - Timeout -> IDLE; set `timeout_err`; no increment.
- Wait counter: 24 bits. Cleared on entry to PU_WAIT and to R_WAIT; increments each cycle while in a wait state.
- Frame-tick pending logic:
  - `vsync` while not in IDLE sets `pending`. This includes the cycle a done pulse arrives.
  - `vsync` while `pending` is already 1 sets `overrun`. The queue is one deep; the extra tick is dropped.
  - `vsync` in IDLE is consumed directly; `pending` is not set.
- Grid mux, combinational from the state register:
  - PU_START and PU_WAIT select `pu_grid_*`.
  - All other states select `rc_grid_*`.
  - `grid_out` is not routed through this block; both engines read it directly.
- Done pulses arriving outside their own wait state are ignored.

## Timing
- Reset values:
  - State = IDLE; `pending` = 0.
  - `cur_*` = START_X / START_Y / START_ANGLE.
  - `pu_start`, `render_start`, `busy`, `overrun`, `timeout_err` = 0.
  - `frame_count` = 0; wait counter = 0.
  - `grid_*` = `rc_grid_*`.
- Reset asserted mid-frame returns the block to IDLE on the next edge. No start pulse is issued that cycle and no commit occurs.
- `vsync` sampled at edge T: `pu_start` is high during cycle T+1.
- `pu_done` sampled at edge D:
  - COMMIT is the state during D+1.
  - New `cur_*` values are visible from D+2.
  - `render_start` is high during D+2.
- `render_done` sampled at edge R: IDLE from R+1; the incremented `frame_count` is visible from R+1.
- Pending tick: if `pending` is set by edge R, PU_START is the state during R+2 (one IDLE cycle).
- Minimum frame length, with done returned in the first wait cycle: 6 cycles from `vsync` to IDLE.
- Timeout: a wait state is left after exactly TIMEOUT cycles in it.
- All outputs are registered except `grid_x`, `grid_y` and `busy`, which decode directly from the state register.

## Test plan
- Reset, then `vsync` at cycle 10; `pu_done` 5 cycles after `pu_start` with next = (600, 520, 8); `render_done` 3 cycles after `render_start` -> `pu_start` high at cycle 11; `cur_*` = (600, 520, 8) two cycles after `pu_done`; `frame_count`=1; `busy`=0 afterwards.
- Drive `pu_grid`=(3,4) and `rc_grid`=(7,9) throughout a frame -> `grid_*`=(3,4) only in PU_START/PU_WAIT; (7,9) in every other state.
- Pulse `vsync` once during R_WAIT -> after `render_done`: one IDLE cycle, then `pu_start`; `overrun`=0. Pulse `vsync` 3 times during one frame -> `overrun`=1 and exactly one extra frame runs.
- With TIMEOUT=16, never assert `pu_done` -> R_START after 16 PU_WAIT cycles; `cur_*` unchanged; `timeout_err`=1; the frame still completes when `render_done` is asserted.
- Assert `reset` during R_WAIT -> next cycle in IDLE; `cur_*` = START values; `frame_count`=0; a stray `render_done` afterwards has no effect.
- Preload by running 65535 frames -> on the next frame `frame_count` wraps to 0.
